// File: rtl/if_id_stall_ctrl_pkg.sv
// pipe_pkg: shared constants for the fetch/decode pipeline registers.
package pipe_pkg;
    localparam logic [31:0] NOP_INST = 32'h0;
    localparam int CTRL_W_DEF = 9;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = {CTRL_W_DEF{1'b0}};
endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; synchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl: PC, IF/ID and bubble-injecting ID/EX control registers
// driven by the load-use hazard signals and the ID-stage branch flush.
module if_id_stall_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc__load,
    input  logic              IFID__Ld,
    input  logic              hazard,
    input  logic              branch__taken,
    input  logic [31:0]       branch__target,
    input  logic [31:0]       inst__in,
    input  logic [CTRL_W-1:0] id__ctrl,
    output logic [31:0]       pc,
    output logic [31:0]       IFID__inst,
    output logic [31:0]       IFID__pc4,
    output logic              IFID__valid,
    output logic [CTRL_W-1:0] IDEX__ctrl,
    output logic [CNT_W-1:0]  stall__cnt,
    output logic [CNT_W-1:0]  flush__cnt,
    output logic              ctrl__err
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            IFID__inst  <= NOP_INST;
            IFID__pc4   <= '0;
            IFID__valid <= 1'b0;
            IDEX__ctrl  <= '0;
            ctrl__err   <= 1'b0;
        end else begin
            pc <= branch__taken ? branch__target : pc__load ? pc + 32'd4 : pc;
            // Flush kills only the fetch behind the branch; the branch itself still reaches ID/EX.
            if (branch__taken) begin
                IFID__inst  <= NOP_INST;
                IFID__pc4   <= '0;
                IFID__valid <= 1'b0;
            end else if (IFID__Ld) begin
                IFID__inst  <= inst__in;
                IFID__pc4   <= pc + 32'd4;
                IFID__valid <= 1'b1;
            end
            IDEX__ctrl <= (hazard && IFID__valid) ? id__ctrl : '0;
            ctrl__err  <= ctrl__err | (pc__load ^ IFID__Ld);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(!hazard), .cnt(stall__cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(branch__taken), .cnt(flush__cnt));
endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// tb_if_id_stall_ctrl: directed + random stimulus, reference model feeds a
// scoreboard queue that a separate monitor drains one entry per clock.
module tb_if_id_stall_ctrl;
    localparam int CTRL_W = 9;
    localparam int CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc, inst, pc4;
        logic valid;
        logic [CTRL_W-1:0] ctrl;
        int s, f;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst, pc__load, IFID__Ld, hazard, branch__taken;
    logic [31:0] branch__target, inst__in;
    logic [CTRL_W-1:0] id__ctrl;
    logic [31:0] pc, IFID__inst, IFID__pc4;
    logic IFID__valid, ctrl__err;
    logic [CTRL_W-1:0] IDEX__ctrl;
    logic [CNT_W-1:0] stall__cnt, flush__cnt;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [31:0] m_pc, m_inst, m_pc4;
    logic m_valid, m_err;
    logic [CTRL_W-1:0] m_ctrl;
    int m_s, m_f;

    always #5 clk = ~clk;

    if_id_stall_ctrl #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc__load(pc__load), .IFID__Ld(IFID__Ld), .hazard(hazard),
        .branch__taken(branch__taken), .branch__target(branch__target), .inst__in(inst__in),
        .id__ctrl(id__ctrl), .pc(pc), .IFID__inst(IFID__inst), .IFID__pc4(IFID__pc4),
        .IFID__valid(IFID__valid), .IDEX__ctrl(IDEX__ctrl), .stall__cnt(stall__cnt),
        .flush__cnt(flush__cnt), .ctrl__err(ctrl__err)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
        end
    endtask

    // Reference model: next state straight from the behavioural rules.
    task automatic drive(input logic r, input logic pl, input logic ld, input logic hz,
                         input logic br, input logic [31:0] tgt, input logic [31:0] ins,
                         input logic [CTRL_W-1:0] c);
        logic [31:0] n_pc, n_inst, n_pc4;
        logic n_valid;
        exp_t e;
        @(negedge clk);
        rst = r; pc__load = pl; IFID__Ld = ld; hazard = hz;
        branch__taken = br; branch__target = tgt; inst__in = ins; id__ctrl = c;
        if (!r) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_ctrl = '0; m_s = 0; m_f = 0; m_err = 1'b0;
        end else begin
            n_pc = br ? tgt : (pl ? 32'((64'(m_pc) + 4) % 64'h1_0000_0000) : m_pc);
            n_inst = m_inst; n_pc4 = m_pc4; n_valid = m_valid;
            if (br) begin n_inst = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; end
            else if (ld) begin n_inst = ins; n_pc4 = 32'((64'(m_pc) + 4) % 64'h1_0000_0000); n_valid = 1'b1; end
            m_ctrl = (hz && m_valid) ? c : '0;
            if (!hz) m_s = (m_s + 1 > CMAX) ? CMAX : m_s + 1;
            if (br) m_f = (m_f + 1 > CMAX) ? CMAX : m_f + 1;
            if (pl != ld) m_err = 1'b1;
            m_pc = n_pc; m_inst = n_inst; m_pc4 = n_pc4; m_valid = n_valid;
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid;
        e.ctrl = m_ctrl; e.s = m_s; e.f = m_f; e.err = m_err;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("ifid_inst", IFID__inst, e.inst);
                chk("ifid_pc4", IFID__pc4, e.pc4);
                chk("ifid_valid", 32'(IFID__valid), 32'(e.valid));
                chk("idex_ctrl", 32'(IDEX__ctrl), 32'(e.ctrl));
                chk("stall_cnt", 32'(stall__cnt), 32'(e.s));
                chk("flush_cnt", 32'(flush__cnt), 32'(e.f));
                chk("ctrl_err", 32'(ctrl__err), 32'(e.err));
            end
        end
    end

    initial begin
        logic pl;
        int budget;
        rst = 1'b0; pc__load = 1'b0; IFID__Ld = 1'b0; hazard = 1'b1; branch__taken = 1'b0;
        branch__target = '0; inst__in = '0; id__ctrl = '0;
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 1, 1, 1, 0, 0, 32'h8C01_0004, 9'h1A5);
        drive(1, 0, 0, 0, 0, 0, 32'h8C01_0004, 9'h1A5);
        drive(1, 1, 1, 1, 0, 0, 32'h0000_1111, 9'h0F3);
        drive(1, 0, 0, 0, 1, 32'h40, 32'h2222_2222, 9'h155);
        drive(1, 1, 1, 1, 0, 0, 32'h3333_3333, 9'h0AA);
        drive(1, 1, 1, 1, 1, 32'hFFFF_FFFC, 32'h4444_4444, 9'h1FF);
        drive(1, 1, 1, 1, 0, 0, 32'h5555_5555, 9'h101);
        drive(1, 1, 1, 1, 0, 0, 32'h6666_6666, 9'h011);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 32'h7777_7777, 9'h1C3);
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 32'h8888_8888, 9'h0C3);
        drive(1, 1, 0, 1, 0, 0, 32'h9999_9999, 9'h123);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0, 0, 32'hAAAA_AAAA, 9'h045);
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            pl = ($urandom_range(3) != 0);
            drive($urandom_range(39) != 0, pl, ($urandom_range(9) == 0) ? !pl : pl,
                  $urandom_range(3) != 0, $urandom_range(7) == 0,
                  ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom & 32'hFFFF_FFFC,
                  $urandom, CTRL_W'($urandom));
        end
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 entries left", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_stall_ctrl.md
Name: if_id_stall_ctrl

Overview:
- Receiving end of the load-use hazard interface. Consumes pc__load, IFID__Ld and hazard (active-low stall), plus the ID-stage branch flush.
- Owns the PC register, the IF/ID pipeline register and the bubble-injecting ID/EX control register.
- Keeps saturating stall and flush counters and a sticky flag for inconsistent stall-control inputs.
- Sits between instruction memory and the decode stage of the MIPS pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 9, width of the decode control bundle passed to ID/EX.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- pc__load  in  1  1 = PC may advance; 0 = hold.
- IFID__Ld  in  1  1 = IF/ID captures new fetch; 0 = hold.
- hazard  in  1  active-low stall: 0 = inject bubble into ID/EX.
- branch__taken  in  1  ID-stage branch/jump resolved taken (flush).
- branch__target  in  32  redirect PC.
- inst__in  in  32  instruction memory read data for the current pc.
- id__ctrl  in  CTRL_W  control bundle decoded from IFID__inst.
- pc  out  32  fetch address.
- IFID__inst  out  32  registered instruction.
- IFID__pc4  out  32  registered pc+4 of that instruction.
- IFID__valid  out  1  IF/ID holds a real instruction.
- IDEX__ctrl  out  CTRL_W  registered control into ID/EX; all-zero is a bubble.
- stall__cnt  out  CNT_W  cycles with hazard==0.
- flush__cnt  out  CNT_W  cycles with branch__taken==1.
- ctrl__err  out  1  sticky; set when pc__load != IFID__Ld.

Behaviour:
- Reset: all state updates on the clk edge where rst==0. Reset values:
  - pc = RESET_PC.
  - IFID__inst = 32'h0 (NOP), IFID__pc4 = 0, IFID__valid = 0.
  - IDEX__ctrl = 0.
  - Both counters = 0, ctrl__err = 0.
  - Reset mid-stall or mid-flush discards everything; there is no pending state.
- PC update, priority order:
  1. branch__taken: pc <= branch__target.
  2. else pc__load: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  3. else hold.
  - Flush overrides a simultaneous stall.
- IF/ID update, priority order:
  1. branch__taken: inst <= NOP, pc4 <= 0, valid <= 0.
  2. else IFID__Ld: inst <= inst__in, pc4 <= pc + 4, valid <= 1.
  3. else hold all three fields unchanged.
- ID/EX control: IDEX__ctrl <= (hazard==1 && IFID__valid==1) ? id__ctrl : 0.
  - One-cycle latency from hazard to bubble.
  - A stall lasting N cycles produces N consecutive zero bundles.
  - Flush does not zero IDEX__ctrl for the branch instruction itself; it only kills the following fetch.
- Counters:
  - stall__cnt increments by 1 on each cycle with hazard==0.
  - flush__cnt increments by 1 on each cycle with branch__taken==1.
  - Both saturate at all-ones and never wrap.
  - Both increment in the same cycle if both events occur.
- ctrl__err: set on any cycle with pc__load != IFID__Ld. Cleared only by reset. Has no effect on the datapath.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (pipe_pkg) holds:
  - NOP_INST = 32'h0.
  - CTRL_W default.
  - RESET_PC default.
  - BUBBLE_CTRL = {CTRL_W{1'b0}}.
- One sub-module: sat_counter (param W; ports clk, rst, inc, cnt; synchronous active-low reset; saturating). Instantiated twice.
- PC, IF/ID and ID/EX registers stay in the top level.

Test Plan:
- Reset then free-run with pc__load=IFID__Ld=hazard=1 and inst__in=32'h8C01_0004:
  - pc sequence 0, 4, 8, 12.
  - Cycle after first fetch: IFID__inst=32'h8C01_0004, IFID__pc4=4, IFID__valid=1.
- Load-use stall: at pc=8, drive pc__load=IFID__Ld=hazard=0 for 1 cycle:
  - pc holds 8 for one cycle; IF/ID holds.
  - IDEX__ctrl=0 on the next edge.
  - stall__cnt=1, ctrl__err=0.
- Branch with simultaneous stall: branch__taken=1, branch__target=32'h40, pc__load=0:
  - pc=32'h40.
  - IFID__valid=0, IFID__inst=0.
  - flush__cnt=1, stall__cnt increments.
- Wrap: force pc to 32'hFFFF_FFFC via branch, then advance once:
  - pc=0.
  - IFID__pc4 captured as 0.
- Saturation with CNT_W=4: hold hazard=0 for 20 cycles:
  - stall__cnt=15 and stays 15.
  - rst=0 for one edge returns it to 0.
- Error flag: pulse pc__load=1 with IFID__Ld=0 for one cycle:
  - ctrl__err=1 and stays 1 after inputs return consistent.
  - Cleared only by rst=0.
